toa_code_assembler: RTL and testbench
=====================================

// Module: toa_code_assembler
// PURPOSE
//  Downstream stage of the TOA fine encoder. Captures the 7-bit fine code, the 2-bit bubble
//  error and the coarse counter on each hit strobe, and forms a linear TOA value
//  (coarse*FINE_BINS + fine). Results go into a small FIFO with a valid/ready output
//  handshake. Keeps saturating hit, bubble-error and drop counters for test readout.
// PARAMETERS
//  COARSE_W   10   coarse counter width
//  FINE_BINS  126  fine bins per coarse period; legal fine codes are 0..FINE_BINS-1
//  FIFO_DEPTH 4    output FIFO entries, power of 2, >=2
//  CNT_W      16   width of the statistics counters
// PORTS
//  clk          in   1             system clock, rising edge
//  rstn         in   1             synchronous reset, active-low
//  hit_valid    in   1             1-cycle strobe: fine/coarse/bubble inputs are valid
//  fine_code    in   7             fine encoder binary output
//  bubble_error in   2             fine encoder bubble error flags
//  coarse_code  in   COARSE_W      coarse counter sampled with the hit
//  cnt_clr      in   1             synchronous clear of all statistics counters
//  toa_valid    out  1             FIFO head is valid
//  toa_ready    in   1             consumer accepts the head when toa_valid & toa_ready
//  toa_data     out  COARSE_W+7    linear TOA of the FIFO head
//  toa_flags    out  3             {range_err, bubble_error[1:0]} of the FIFO head
//  hit_cnt      out  CNT_W         hits accepted into the FIFO, saturating
//  bub_cnt      out  CNT_W         hits with bubble_error!=0, saturating
//  drop_cnt     out  CNT_W         hits lost (FIFO full or filtered), saturating
// BEHAVIOUR
//  Reset (rstn=0 at a clk edge): FIFO empty, pipeline valid bits cleared, toa_valid=0,
//   toa_data=0, toa_flags=0, all counters=0. Reset mid-operation discards in-flight hits.
//   No counter increments during reset.
//  S1 (capture): hit_valid registers fine_code, bubble_error and coarse_code, and sets s1_vld.
//  S2 (compute):
//   - range_err = (fine > FINE_BINS-1). When range_err=1, fine is clamped to FINE_BINS-1.
//   - toa = coarse*FINE_BINS + fine_clamped, computed at full width COARSE_W+7, no wrap.
//  FIFO write occurs in the cycle after S1. With an empty FIFO, toa_valid rises 2 cycles
//   after hit_valid (hit at edge N -> toa_valid high after edge N+2).
//  Back-to-back hit_valid every cycle is supported at full throughput.
//  Handshake:
//   - toa_data and toa_flags are held stable while toa_valid & !toa_ready.
//   - Pop on toa_valid & toa_ready. The FIFO drives its head from registers, with no
//     combinational path from toa_ready to toa_valid.
//  Full: a write is accepted if the FIFO is not full, or if a pop happens in the same cycle.
//   Otherwise the hit is dropped and drop_cnt increments; the FIFO contents are unchanged.
//  Pointers wrap modulo FIFO_DEPTH. A separate occupancy count distinguishes full from empty.
//  Counters:
//   - hit_cnt increments on an accepted write.
//   - bub_cnt increments when an S2 entry has bubble_error!=0, whether accepted or not.
//   - All counters saturate at 2^CNT_W-1.
//   - cnt_clr has priority over an increment in the same cycle; counters read 0 next cycle.
//  The state machine is implicit in the valid bits: EMPTY (count 0), PARTIAL, FULL
//   (count FIFO_DEPTH). A simultaneous push and pop leaves the count unchanged.
// CONFIGURATION
//  TOA_BUBBLE_FILTER_EN:
//   - Defined: S2 entries with bubble_error!=0 are never written to the FIFO. drop_cnt and
//     bub_cnt both increment. toa_flags[1:0] always reads 0.
//   - Not defined: such entries are written normally, with bubble_error in toa_flags[1:0].
// TESTING
//  1. Empty FIFO, toa_ready=1, hit with coarse=3, fine=5 -> toa_data=383, flags=0,
//     toa_valid high for 1 cycle, 2 cycles after the hit; hit_cnt=1.
//  2. fine=127, coarse=0 -> toa_data=125, flags=3'b100 (range_err).
//  3. toa_ready=0, 6 back-to-back hits, FIFO_DEPTH=4 -> first 4 held in order, drop_cnt=2,
//     hit_cnt=4; on release, 4 pops in order, then toa_valid=0.
//  4. FIFO full with toa_ready=1 and a hit in the same cycle -> the hit is accepted, no drop,
//     count stays 4.
//  5. bubble_error=2'b01 hit -> bub_cnt=1. Without the macro: flags=3'b001, hit_cnt=1.
//     With the macro: no output, drop_cnt=1.
//  6. rstn=0 for 1 cycle while 3 entries are queued -> toa_valid=0 and all counters 0 next
//     cycle. cnt_clr held with hits every cycle -> counters stay 0.

Source files
------------

// File: rtl/toa_code_assembler.sv
// TOA code assembler: captures fine/coarse/bubble on a hit, forms coarse*FINE_BINS+fine,
// queues results in a small valid/ready FIFO and keeps saturating statistics counters.
// Optional build macro: TOA_BUBBLE_FILTER_EN drops hits that carry a bubble error.
module toa_code_assembler #(
  parameter int COARSE_W   = 10,
  parameter int FINE_BINS  = 126,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  hit_valid,
  input  logic [6:0]            fine_code,
  input  logic [1:0]            bubble_error,
  input  logic [COARSE_W-1:0]   coarse_code,
  input  logic                  cnt_clr,
  output logic                  toa_valid,
  input  logic                  toa_ready,
  output logic [COARSE_W+6:0]   toa_data,
  output logic [2:0]            toa_flags,
  output logic [CNT_W-1:0]      hit_cnt,
  output logic [CNT_W-1:0]      bub_cnt,
  output logic [CNT_W-1:0]      drop_cnt
);

  localparam int TOA_W = COARSE_W + 7;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam logic [6:0] FINE_MAX = 7'(FINE_BINS - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + 1'b1 : v;
  endfunction

  function automatic logic [6:0] clamp_fine(input logic [6:0] f);
    return (f > FINE_MAX) ? FINE_MAX : f;
  endfunction

  // Stage p0: capture the hit
  logic                vld_p0;
  logic [6:0]          fine_p0;
  logic [1:0]          bub_p0;
  logic [COARSE_W-1:0] coarse_p0;

  always_ff @(posedge clk) begin
    if (!rstn) vld_p0 <= 1'b0;
    else       vld_p0 <= hit_valid;
  end

  always_ff @(posedge clk) begin
    if (hit_valid) begin
      fine_p0   <= fine_code;
      bub_p0    <= bubble_error;
      coarse_p0 <= coarse_code;
    end
  end

  // Stage p1: range check, clamp and linearise
  logic             range_err;
  logic [TOA_W-1:0] toa_calc;
  logic             vld_p1;
  logic [TOA_W-1:0] toa_p1;
  logic [2:0]       flags_p1;
  logic [1:0]       bub_p1;

  always_comb begin
    range_err = (fine_p0 > FINE_MAX);
    toa_calc  = TOA_W'(coarse_p0) * TOA_W'(FINE_BINS) + TOA_W'(clamp_fine(fine_p0));
  end

  always_ff @(posedge clk) begin
    if (!rstn) vld_p1 <= 1'b0;
    else       vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    if (vld_p0) begin
      toa_p1 <= toa_calc;
      bub_p1 <= bub_p0;
`ifdef TOA_BUBBLE_FILTER_EN
      flags_p1 <= {range_err, 2'b00};
`else
      flags_p1 <= {range_err, bub_p0};
`endif
    end
  end

  // Stage p2: FIFO write, head register and statistics
  logic [TOA_W-1:0] mem_toa   [FIFO_DEPTH];
  logic [2:0]       mem_flags [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             full;
  logic             pop;
  logic             push;
  logic             filtered;
  logic             bub_hit;

  always_comb begin
`ifdef TOA_BUBBLE_FILTER_EN
    filtered = (bub_p1 != 2'b00);
`else
    filtered = 1'b0;
`endif
    bub_hit   = vld_p1 && (bub_p1 != 2'b00);
    full      = (occ == OCC_W'(FIFO_DEPTH));
    toa_valid = (occ != '0);
    pop       = toa_valid && toa_ready;
    // A full FIFO still takes a write when the head leaves in the same cycle
    push      = vld_p1 && !filtered && (!full || pop);
    toa_data  = toa_valid ? mem_toa[rd_ptr]   : '0;
    toa_flags = toa_valid ? mem_flags[rd_ptr] : 3'b000;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_toa[wr_ptr]   <= toa_p1;
      mem_flags[wr_ptr] <= flags_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || cnt_clr) begin
      hit_cnt  <= '0;
      bub_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      hit_cnt  <= sat_inc(hit_cnt, push);
      bub_cnt  <= sat_inc(bub_cnt, bub_hit);
      drop_cnt <= sat_inc(drop_cnt, vld_p1 && !push);
    end
  end

endmodule

// File: tb/tb_toa_code_assembler.sv
// Randomised and directed bench for toa_code_assembler against a queue-based reference model.
// Honours TOA_BUBBLE_FILTER_EN the same way as the design.
module tb_toa_code_assembler;

  localparam int COARSE_W   = 10;
  localparam int FINE_BINS  = 126;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 4;
  localparam int CMAX       = (1 << CNT_W) - 1;

  logic                clk = 1'b0;
  logic                rstn;
  logic                hit_valid;
  logic [6:0]          fine_code;
  logic [1:0]          bubble_error;
  logic [COARSE_W-1:0] coarse_code;
  logic                cnt_clr;
  logic                toa_valid;
  logic                toa_ready;
  logic [COARSE_W+6:0] toa_data;
  logic [2:0]          toa_flags;
  logic [CNT_W-1:0]    hit_cnt;
  logic [CNT_W-1:0]    bub_cnt;
  logic [CNT_W-1:0]    drop_cnt;

  toa_code_assembler #(
    .COARSE_W(COARSE_W), .FINE_BINS(FINE_BINS), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rstn(rstn), .hit_valid(hit_valid), .fine_code(fine_code),
    .bubble_error(bubble_error), .coarse_code(coarse_code), .cnt_clr(cnt_clr),
    .toa_valid(toa_valid), .toa_ready(toa_ready), .toa_data(toa_data),
    .toa_flags(toa_flags), .hit_cnt(hit_cnt), .bub_cnt(bub_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { bit v; int fine; int bub; int coarse; } hit_t;
  typedef struct { int data; int flags; } ent_t;

  hit_t hist [4];
  ent_t q [$];
  int   m_hit, m_bub, m_drop;
  int   k;
  int   n_err, n_chk;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input bit en);
    return (en && v < CMAX) ? v + 1 : v;
  endfunction

  // One clock: apply inputs, advance the model for that edge, then compare at the falling edge.
  task automatic step(input bit hv, input int fine, input int bub, input int coarse,
                      input bit rdy, input bit clr, input bit rs);
    hit_t c;
    int   sz, fc, fl;
    bit   pop, push, filt;
    hit_valid    = hv;
    fine_code    = 7'(fine);
    bubble_error = 2'(bub);
    coarse_code  = COARSE_W'(coarse);
    toa_ready    = rdy;
    cnt_clr      = clr;
    rstn         = rs;
    if (!rs) begin
      q.delete();
      m_hit = 0; m_bub = 0; m_drop = 0;
      hist[(k + 3) % 4].v = 1'b0;
      hist[k % 4].v       = 1'b0;
    end else begin
      c    = hist[(k + 2) % 4];
      sz   = q.size();
      pop  = (sz > 0) && rdy;
      push = 1'b0;
      filt = 1'b0;
`ifdef TOA_BUBBLE_FILTER_EN
      filt = (c.bub != 0);
`endif
      if (pop) void'(q.pop_front());
      if (c.v && !filt && (sz < FIFO_DEPTH || pop)) begin
        push = 1'b1;
        fc   = (c.fine > FINE_BINS - 1) ? FINE_BINS - 1 : c.fine;
        fl   = (c.fine > FINE_BINS - 1) ? 4 : 0;
`ifndef TOA_BUBBLE_FILTER_EN
        fl   = fl + c.bub;
`endif
        q.push_back('{c.coarse * FINE_BINS + fc, fl});
      end
      if (clr) begin
        m_hit = 0; m_bub = 0; m_drop = 0;
      end else begin
        m_hit  = sat(m_hit, push);
        m_bub  = sat(m_bub, c.v && c.bub != 0);
        m_drop = sat(m_drop, c.v && !push);
      end
      hist[k % 4] = '{hv, fine, bub, coarse};
    end
    k++;
    @(posedge clk);
    @(negedge clk);
    check("toa_valid", int'(toa_valid), (q.size() > 0) ? 1 : 0);
    if (q.size() > 0) begin
      check("toa_data", int'(toa_data), q[0].data);
      check("toa_flags", int'(toa_flags), q[0].flags);
    end
    check("hit_cnt", int'(hit_cnt), m_hit);
    check("bub_cnt", int'(bub_cnt), m_bub);
    check("drop_cnt", int'(drop_cnt), m_drop);
  endtask

  task automatic idle(input bit rdy, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, rdy, 1'b0, 1'b1);
  endtask

  initial begin
    int rdy_pct [6] = '{90, 40, 10, 100, 60, 5};
    int f, b, cc, p;
    n_err = 0; n_chk = 0; k = 0;
    m_hit = 0; m_bub = 0; m_drop = 0;
    for (int i = 0; i < 4; i++) hist[i] = '{1'b0, 0, 0, 0};

    step(1'b0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
    check("rst_data", int'(toa_data), 0);
    check("rst_flags", int'(toa_flags), 0);

    // coarse=3, fine=5 -> 383, visible two edges after the hit for one cycle
    idle(1'b1, 2);
    step(1'b1, 5, 0, 3, 1'b1, 1'b0, 1'b1);
    idle(1'b1, 1);
    check("t1_early", int'(toa_valid), 0);
    idle(1'b1, 1);
    check("t1_valid", int'(toa_valid), 1);
    check("t1_data", int'(toa_data), 383);
    idle(1'b1, 1);
    check("t1_gone", int'(toa_valid), 0);
    check("t1_hits", int'(hit_cnt), 1);

    // out-of-range fine code clamps and flags
    step(1'b1, 127, 0, 0, 1'b1, 1'b0, 1'b1);
    idle(1'b1, 2);
    check("t2_data", int'(toa_data), 125);
    check("t2_flags", int'(toa_flags), 4);
    idle(1'b1, 2);

    // stalled consumer, six hits into a four-entry FIFO
    step(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 10 + i, 0, i, 1'b0, 1'b0, 1'b1);
    idle(1'b0, 2);
    check("t3_drop", int'(drop_cnt), 2);
    check("t3_hits", int'(hit_cnt), 4);

    // full FIFO, pop and push land on the same edge
    step(1'b1, 20, 0, 50, 1'b0, 1'b0, 1'b1);
    idle(1'b0, 1);
    idle(1'b1, 1);
    check("t4_drop", int'(drop_cnt), 2);
    check("t4_hits", int'(hit_cnt), 5);
    idle(1'b1, 4);
    check("t4_drained", int'(toa_valid), 0);
    idle(1'b1, 2);

    // bubble error
    step(1'b0, 0, 0, 0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 9, 1, 7, 1'b0, 1'b0, 1'b1);
    idle(1'b0, 2);
    check("t5_bub", int'(bub_cnt), 1);
`ifdef TOA_BUBBLE_FILTER_EN
    check("t5_drop", int'(drop_cnt), 1);
    check("t5_valid", int'(toa_valid), 0);
`else
    check("t5_flags", int'(toa_flags), 1);
    check("t5_hits", int'(hit_cnt), 1);
`endif
    idle(1'b1, 3);

    // reset with entries queued, then clear held against continuous hits
    for (int i = 0; i < 3; i++) step(1'b1, i, 0, 100 + i, 1'b0, 1'b0, 1'b1);
    idle(1'b0, 2);
    step(1'b1, 1, 0, 1, 1'b0, 1'b0, 1'b0);
    check("t6_valid", int'(toa_valid), 0);
    check("t6_hits", int'(hit_cnt), 0);
    check("t6_drop", int'(drop_cnt), 0);
    for (int i = 0; i < 8; i++) step(1'b1, i, i % 4, i, 1'b0, 1'b1, 1'b1);
    check("t6_clr_hits", int'(hit_cnt), 0);
    check("t6_clr_bub", int'(bub_cnt), 0);
    check("t6_clr_drop", int'(drop_cnt), 0);

    // randomised traffic with varying back-pressure, saturation, clears and resets
    for (int i = 0; i < 3000; i++) begin
      p  = rdy_pct[(i / 500) % 6];
      f  = ($urandom % 8 == 0) ? 126 + int'($urandom % 2) : int'($urandom % 128);
      b  = ($urandom % 6 == 0) ? int'($urandom % 4) : 0;
      cc = ($urandom % 10 == 0) ? (1 << COARSE_W) - 1 : int'($urandom % (1 << COARSE_W));
      step(($urandom % 100) < 70, f, b, cc, ($urandom % 100) < p,
           ($urandom % 100) == 0, ($urandom % 400) != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
